// File: rtl/rs_pkg.sv
// Shared widths and entry layout for the reservation station slice.
// The package constants are the single source for the struct field widths.
package rs_pkg;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 3;
    localparam int OP_W   = 4;

    typedef struct packed {
        logic                     busy;
        logic signed [DATA_W-1:0] v_i;
        logic signed [DATA_W-1:0] v_j;
        logic [ROB_W-1:0]         q_i;
        logic [ROB_W-1:0]         q_j;
        logic                     i_ready;
        logic                     j_ready;
        logic [OP_W-1:0]          opcode;
        logic [ROB_W-1:0]         rob_idx;
    } rs_entry_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_select_oldest.sv
// Combinational picker: among ready entries, grants the one with the largest age.
// Ages are unique among busy entries, so no tie-break is needed.
module rs_select_oldest #(
    parameter int N_ENTRIES = 4,
    parameter int AGE_W     = 2,
    parameter int IDX_W     = 2
) (
    input  logic [N_ENTRIES-1:0]            ready,
    input  logic [N_ENTRIES-1:0][AGE_W-1:0] age,
    output logic                            grant_valid,
    output logic [IDX_W-1:0]                grant_idx
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_age    = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (ready[i] && (!grant_valid || age[i] > best_age)) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
                best_age    = age[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station_core.sv
// Single-issue reservation station: buffers dispatched ops and issues the oldest
// ready one to the FU each cycle it is free. All outputs except rs_free are registered.
module reservation_station_core #(
    parameter int N_ENTRIES = 4,
    parameter int DATA_W    = rs_pkg::DATA_W,
    parameter int ROB_W     = rs_pkg::ROB_W,
    parameter int OP_W      = rs_pkg::OP_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_input_in,
    input  logic                     fu_busy_in,
    input  logic [ROB_W-1:0]         Q_i_in,
    input  logic [ROB_W-1:0]         Q_j_in,
    input  logic signed [DATA_W-1:0] V_i_in,
    input  logic signed [DATA_W-1:0] V_j_in,
    input  logic [ROB_W-1:0]         rob_idx_in,
    input  logic [OP_W-1:0]          opcode_in,
    input  logic                     i_ready_in,
    input  logic                     j_ready_in,
    output logic signed [DATA_W-1:0] rval1_out,
    output logic signed [DATA_W-1:0] rval2_out,
    output logic [OP_W-1:0]          opcode_out,
    output logic [ROB_W-1:0]         rob_idx_out,
    output logic                     rs_free_for_input_out,
    output logic                     rs_output_valid_out
);

    import rs_pkg::*;

    localparam int IDX_W = idx_width(N_ENTRIES);
    // Age = number of younger busy entries, so it never exceeds N_ENTRIES-1.
    localparam int AGE_W = IDX_W;

    rs_entry_t                      entries [N_ENTRIES];
    logic [N_ENTRIES-1:0][AGE_W-1:0] age_q;
    logic [N_ENTRIES-1:0]           ready;
    logic [IDX_W-1:0]               free_idx;
    logic                           grant_valid;
    logic [IDX_W-1:0]               grant_idx;
    logic [AGE_W-1:0]               issued_age;
    logic                           do_alloc;
    logic                           do_issue;
    rs_entry_t                      new_entry;

    always_comb begin
        rs_free_for_input_out = 1'b0;
        free_idx              = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            ready[i] = entries[i].busy & entries[i].i_ready & entries[i].j_ready;
            if (!entries[i].busy) begin
                rs_free_for_input_out = 1'b1;
                free_idx              = IDX_W'(i);
            end
        end
    end

    rs_select_oldest #(
        .N_ENTRIES (N_ENTRIES),
        .AGE_W     (AGE_W),
        .IDX_W     (IDX_W)
    ) u_select (
        .ready       (ready),
        .age         (age_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign do_alloc   = valid_input_in & rs_free_for_input_out;
    assign do_issue   = ~fu_busy_in & grant_valid;
    assign issued_age = age_q[grant_idx];

    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.v_i     = V_i_in;
        new_entry.v_j     = V_j_in;
        new_entry.q_i     = Q_i_in;
        new_entry.q_j     = Q_j_in;
        new_entry.i_ready = i_ready_in;
        new_entry.j_ready = j_ready_in;
        new_entry.opcode  = opcode_in;
        new_entry.rob_idx = rob_idx_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_ENTRIES; i++) entries[i] <= '0;
            age_q               <= '0;
            rval1_out           <= '0;
            rval2_out           <= '0;
            opcode_out          <= '0;
            rob_idx_out         <= '0;
            rs_output_valid_out <= 1'b0;
        end else begin
            rs_output_valid_out <= do_issue;
            if (do_issue) begin
                rval1_out   <= entries[grant_idx].v_i;
                rval2_out   <= entries[grant_idx].v_j;
                opcode_out  <= entries[grant_idx].opcode;
                rob_idx_out <= entries[grant_idx].rob_idx;
                entries[grant_idx].busy <= 1'b0;
            end
            // Older survivors close the gap left by the issued entry.
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (entries[i].busy)
                    age_q[i] <= age_q[i] + AGE_W'(do_alloc)
                                - AGE_W'(do_issue && (age_q[i] > issued_age));
            end
            if (do_alloc) begin
                entries[free_idx] <= new_entry;
                age_q[free_idx]   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_core.sv
// Self-checking bench: issue predictions are queued at dispatch and compared
// by a monitor when rs_output_valid_out pulses.
module tb_reservation_station_core;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               valid_input_in;
    logic               fu_busy_in;
    logic [2:0]         Q_i_in, Q_j_in;
    logic signed [31:0] V_i_in, V_j_in;
    logic [2:0]         rob_idx_in;
    logic [3:0]         opcode_in;
    logic               i_ready_in, j_ready_in;
    logic signed [31:0] rval1_out, rval2_out;
    logic [3:0]         opcode_out;
    logic [2:0]         rob_idx_out;
    logic               rs_free_for_input_out;
    logic               rs_output_valid_out;

    always #5 clk_in = ~clk_in;

    reservation_station_core dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .valid_input_in        (valid_input_in),
        .fu_busy_in            (fu_busy_in),
        .Q_i_in                (Q_i_in),
        .Q_j_in                (Q_j_in),
        .V_i_in                (V_i_in),
        .V_j_in                (V_j_in),
        .rob_idx_in            (rob_idx_in),
        .opcode_in             (opcode_in),
        .i_ready_in            (i_ready_in),
        .j_ready_in            (j_ready_in),
        .rval1_out             (rval1_out),
        .rval2_out             (rval2_out),
        .opcode_out            (opcode_out),
        .rob_idx_out           (rob_idx_out),
        .rs_free_for_input_out (rs_free_for_input_out),
        .rs_output_valid_out   (rs_output_valid_out)
    );

    typedef struct {
        logic signed [31:0] v1;
        logic signed [31:0] v2;
        logic [3:0]         op;
        logic [2:0]         rob;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    always @(negedge clk_in) begin
        if (rs_output_valid_out === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue got rob=%0d v1=%0d v2=%0d, expected no issue",
                         rob_idx_out, rval1_out, rval2_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (rval1_out !== mon_e.v1 || rval2_out !== mon_e.v2 ||
                    opcode_out !== mon_e.op || rob_idx_out !== mon_e.rob) begin
                    errors++;
                    $display("FAIL issue_fields got v1=%0d v2=%0d op=%0d rob=%0d, expected v1=%0d v2=%0d op=%0d rob=%0d",
                             rval1_out, rval2_out, opcode_out, rob_idx_out,
                             mon_e.v1, mon_e.v2, mon_e.op, mon_e.rob);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_exp(input logic signed [31:0] v1, input logic signed [31:0] v2,
                            input logic [3:0] op, input logic [2:0] rob);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.op = op; e.rob = rob;
        exp_q.push_back(e);
    endtask

    task automatic set_alloc(input logic signed [31:0] vi, input logic signed [31:0] vj,
                             input logic [3:0] op, input logic [2:0] rob,
                             input logic ir, input logic jr);
        valid_input_in = 1'b1;
        V_i_in = vi; V_j_in = vj;
        opcode_in = op; rob_idx_in = rob;
        i_ready_in = ir; j_ready_in = jr;
        Q_i_in = rob + 3'd1; Q_j_in = rob + 3'd2;
    endtask

    task automatic alloc_one(input logic signed [31:0] vi, input logic signed [31:0] vj,
                             input logic [3:0] op, input logic [2:0] rob,
                             input logic ir, input logic jr);
        set_alloc(vi, vj, op, rob, ir, jr);
        tick();
        valid_input_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_input_in = 1'b0; fu_busy_in = 1'b1;
        V_i_in = '0; V_j_in = '0; Q_i_in = '0; Q_j_in = '0;
        rob_idx_in = '0; opcode_in = '0; i_ready_in = 1'b0; j_ready_in = 1'b0;
        tick(2);
        rst_in = 1'b0;
        tick();
        checks++;
        if (rs_output_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b expected 0", rs_output_valid_out);
        end
        checks++;
        if (rs_free_for_input_out !== 1'b1) begin
            errors++; $display("FAIL reset_free got %b expected 1", rs_free_for_input_out);
        end
        checks++;
        if (rval1_out !== 0 || rval2_out !== 0 || opcode_out !== 0 || rob_idx_out !== 0) begin
            errors++;
            $display("FAIL reset_data got v1=%0d v2=%0d op=%0d rob=%0d expected all 0",
                     rval1_out, rval2_out, opcode_out, rob_idx_out);
        end
    endtask

    task automatic test_hold_while_busy();
        int p0;
        p0 = pulses;
        fu_busy_in = 1'b1;
        alloc_one(3, 3, 4'd2, 3'd1, 1'b1, 1'b1);
        tick(10);
        alloc_one(5, 5, 4'd3, 3'd2, 1'b1, 1'b1);
        tick(10);
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL hold_no_issue got %0d pulses expected 0", pulses - p0);
        end
        push_exp(3, 3, 4'd2, 3'd1);
        fu_busy_in = 1'b0;
        tick();
        fu_busy_in = 1'b1;
        tick(4);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++; $display("FAIL hold_one_pulse got %0d pulses expected 1", pulses - p0);
        end
        checks++;
        if (rval1_out !== 3 || rs_output_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_data_kept got v1=%0d valid=%b expected v1=3 valid=0",
                     rval1_out, rs_output_valid_out);
        end
        push_exp(5, 5, 4'd3, 3'd2);
        fu_busy_in = 1'b0;
        tick(3);
        checks++;
        if (pulses - p0 !== 2) begin
            errors++; $display("FAIL hold_drain got %0d pulses expected 2", pulses - p0);
        end
    endtask

    task automatic test_fill_drop();
        int p0;
        p0 = pulses;
        fu_busy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_one(10 + i, -10 - i, 4'(i + 1), 3'(i), 1'b1, 1'b1);
            push_exp(10 + i, -10 - i, 4'(i + 1), 3'(i));
        end
        checks++;
        if (rs_free_for_input_out !== 1'b0) begin
            errors++; $display("FAIL fill_full got free=%b expected 0", rs_free_for_input_out);
        end
        alloc_one(99, 99, 4'd15, 3'd7, 1'b1, 1'b1);
        fu_busy_in = 1'b0;
        tick(8);
        checks++;
        if (pulses - p0 !== 4) begin
            errors++; $display("FAIL fill_drain_count got %0d expected 4", pulses - p0);
        end
        checks++;
        if (rs_free_for_input_out !== 1'b1) begin
            errors++; $display("FAIL fill_free_after got %b expected 1", rs_free_for_input_out);
        end
    endtask

    task automatic test_same_edge();
        int p0;
        p0 = pulses;
        fu_busy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_one(-100 * (i + 1), 7 * i, 4'(8 + i), 3'(4 + i), 1'b1, 1'b1);
            push_exp(-100 * (i + 1), 7 * i, 4'(8 + i), 3'(4 + i));
        end
        checks++;
        if (rs_free_for_input_out !== 1'b0) begin
            errors++; $display("FAIL same_edge_full got free=%b expected 0", rs_free_for_input_out);
        end
        set_alloc(77, 77, 4'd1, 3'd3, 1'b1, 1'b1);
        fu_busy_in = 1'b0;
        tick();
        valid_input_in = 1'b0;
        checks++;
        if (rs_free_for_input_out !== 1'b1) begin
            errors++; $display("FAIL same_edge_free got %b expected 1", rs_free_for_input_out);
        end
        tick(6);
        checks++;
        if (pulses - p0 !== 4) begin
            errors++; $display("FAIL same_edge_count got %0d expected 4", pulses - p0);
        end
    endtask

    task automatic test_oldest_ready();
        int p0;
        p0 = pulses;
        fu_busy_in = 1'b0;
        alloc_one(1, 1, 4'd4, 3'd3, 1'b0, 1'b1);
        push_exp(-4, 8, 4'd9, 3'd5);
        alloc_one(-4, 8, 4'd9, 3'd5, 1'b1, 1'b1);
        tick(3);
        checks++;
        if (pulses - p0 !== 1 || rob_idx_out !== 3'd5) begin
            errors++;
            $display("FAIL oldest_ready got pulses=%0d rob=%0d expected 1 and 5", pulses - p0, rob_idx_out);
        end
        push_exp(21, -22, 4'd6, 3'd6);
        alloc_one(21, -22, 4'd6, 3'd6, 1'b1, 1'b1);
        tick(3);
        checks++;
        if (pulses - p0 !== 2 || rob_idx_out !== 3'd6) begin
            errors++;
            $display("FAIL younger_after_unready got pulses=%0d rob=%0d expected 2 and 6", pulses - p0, rob_idx_out);
        end
        checks++;
        if (rs_free_for_input_out !== 1'b1) begin
            errors++; $display("FAIL unready_resident_free got %b expected 1", rs_free_for_input_out);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pulses;
        fu_busy_in = 1'b1;
        alloc_one(40, 41, 4'd2, 3'd1, 1'b1, 1'b1);
        alloc_one(42, 43, 4'd3, 3'd2, 1'b1, 1'b1);
        checks++;
        if (rs_free_for_input_out !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre_free got %b expected 1", rs_free_for_input_out);
        end
        rst_in = 1'b1;
        fu_busy_in = 1'b0;
        tick();
        rst_in = 1'b0;
        tick(5);
        checks++;
        if (pulses - p0 !== 0 || rs_output_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse got pulses=%0d valid=%b expected 0 and 0",
                     pulses - p0, rs_output_valid_out);
        end
        fu_busy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_one(60 + i, 70 + i, 4'(i), 3'(7 - i), 1'b1, 1'b1);
            push_exp(60 + i, 70 + i, 4'(i), 3'(7 - i));
        end
        checks++;
        if (rs_free_for_input_out !== 1'b0) begin
            errors++; $display("FAIL reset_mid_refill got free=%b expected 0", rs_free_for_input_out);
        end
        fu_busy_in = 1'b0;
        tick(8);
        checks++;
        if (pulses - p0 !== 4) begin
            errors++; $display("FAIL reset_mid_drain got %0d expected 4", pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_hold_while_busy();
        test_fill_drop();
        test_same_edge();
        test_oldest_ready();
        test_reset_mid();
        tick(2);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_empty got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
